draw_rect_ctl: RTL

Frame-rate motion controller for the rectangle/sprite drawing stage of the VGA pipeline. It produces the `xpos`/`ypos` that the rect/image drawer consumes. In FOLLOW it tracks the mouse. A left click drops the rectangle under per-frame gravity with damped bounces off the screen floor until it comes to rest. It sits beside the `draw_bg → draw_rect` chain, taps that chain's `vga_if` for frame timing, and owns no pixel data.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_if.sv | 26 ++
 rtl/edge_det.sv | 33 +++
 rtl/draw_rect_ctl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA pipeline constants and types
//
// Purpose: screen geometry and the rectangle-motion state type, shared by
//          the drawing stages of the VGA pipeline.
// Ports:   none (package).

package vga_pkg;

   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;

   // Encoding is visible on state_o, so keep the values fixed.
   typedef enum logic [1:0] {
      FOLLOW = 2'd0,
      FALL   = 2'd1,
      REST   = 2'd2
   } rect_state_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing/pixel bundle passed between drawing stages
//
// Purpose: carries the raster counters, sync/blank strobes and pixel colour
//          from one drawing stage to the next.
// Ports:   modport out - driving stage (all signals output)
//          modport in  - consuming stage or timing tap (all signals input)

interface vga_if;

   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport out (
      output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
   );

   modport in (
      input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
   );

endinterface

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered rising-edge pulse detector
//
// Purpose: emits a one-cycle pulse on the cycle after din rises 0->1.
// Ports:   clk   in  clock
//          rst   in  asynchronous active-high reset
//          din   in  level to watch (already synchronous to clk)
//          pulse out registered one-cycle rising-edge pulse

module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic prev;
   logic primed;

   // primed stays low for the first cycle after reset so that a level which
   // is already high at reset release is taken as history, not as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev   <= 1'b0;
         primed <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         prev   <= din;
         primed <= 1'b1;
         pulse  <= primed & din & ~prev;
      end
   end

endmodule

// File: rtl/draw_rect_ctl.sv
// rtl/draw_rect_ctl.sv - frame-rate follow/fall/bounce controller for the rectangle
//
// Purpose: produces the rectangle top-left position. Tracks the mouse in
//          FOLLOW; a left click drops the rectangle under per-frame gravity
//          with damped floor bounces until it settles in REST.
// Ports:   clk        in  pixel clock
//          rst        in  asynchronous active-high reset
//          in         vga_if.in timing tap (only vblnk is used)
//          mouse_xpos in  mouse x, unsigned
//          mouse_ypos in  mouse y, unsigned
//          mouse_left in  left button level, synchronous to clk
//          xpos       out rectangle x, registered
//          ypos       out rectangle y, registered
//          state_o    out current state (FOLLOW=0, FALL=1, REST=2)

module draw_rect_ctl
   import vga_pkg::*;
#(
   parameter int RECT_HEIGHT  = 64,
   parameter int FLOOR_Y      = VER_PIXELS,
   parameter int GRAVITY      = 1,
   parameter int BOUNCE_SHIFT = 1,
   parameter int MIN_VEL      = 2,
   parameter int MAX_VEL      = 63
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           in,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic [1:0]  state_o
);

   localparam int                 YLIM   = FLOOR_Y - RECT_HEIGHT;
   localparam logic [11:0]        YLIM_U = 12'(YLIM);
   localparam logic signed [12:0] YLIM_S = 13'(YLIM);
   localparam logic signed [11:0] GRAV_S = 12'(GRAVITY);
   localparam logic signed [11:0] MAXV_S = 12'(MAX_VEL);
   localparam logic signed [11:0] MINV_S = 12'(MIN_VEL);

   logic tick;
   logic click;

   edge_det u_tick_det (
      .clk   (clk),
      .rst   (rst),
      .din   (in.vblnk),
      .pulse (tick)
   );

   edge_det u_click_det (
      .clk   (clk),
      .rst   (rst),
      .din   (mouse_left),
      .pulse (click)
   );

   rect_state_t        state;
   rect_state_t        state_nxt;
   logic signed [11:0] vel;
   logic signed [11:0] vel_nxt;
   logic [11:0]        xpos_nxt;
   logic [11:0]        ypos_nxt;

   logic signed [11:0] vel_sum;
   logic signed [11:0] vel_n;
   logic signed [12:0] y_n;
   logic signed [11:0] rebound;
   logic [11:0]        mouse_y_clamped;

   // One physics step's worth of candidate values; only consumed on a tick.
   always_comb begin
      vel_sum         = vel + GRAV_S;
      vel_n           = (vel_sum > MAXV_S) ? MAXV_S : vel_sum;
      // ypos is never above YLIM, so 13 signed bits hold position + velocity.
      y_n             = $signed({1'b0, ypos}) + $signed({vel_n[11], vel_n});
      rebound         = vel_n >>> BOUNCE_SHIFT;
      mouse_y_clamped = (mouse_ypos > YLIM_U) ? YLIM_U : mouse_ypos;
   end

   always_comb begin
      state_nxt = state;
      vel_nxt   = vel;
      xpos_nxt  = xpos;
      ypos_nxt  = ypos;
      case (state)
         FOLLOW: begin
            if (click) begin
               // Position freezes on the click cycle itself.
               state_nxt = FALL;
               vel_nxt   = '0;
            end else begin
               xpos_nxt = mouse_xpos;
               ypos_nxt = mouse_y_clamped;
            end
         end
         FALL: begin
            // A click pre-empts any physics step that lands on the same cycle.
            if (click) begin
               state_nxt = FOLLOW;
               vel_nxt   = '0;
            end else if (tick) begin
               if (y_n >= YLIM_S) begin
                  ypos_nxt = YLIM_U;
                  if (rebound < MINV_S) begin
                     state_nxt = REST;
                     vel_nxt   = '0;
                  end else begin
                     vel_nxt = -rebound;
                  end
               end else if (y_n < 13'sd0) begin
                  ypos_nxt = '0;
                  vel_nxt  = '0;
               end else begin
                  ypos_nxt = y_n[11:0];
                  vel_nxt  = vel_n;
               end
            end
         end
         REST: begin
            if (click) begin
               state_nxt = FOLLOW;
            end
         end
         default: begin
            // Encoding 3 should never occur; recover to a known state.
            state_nxt = FOLLOW;
            vel_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FOLLOW;
         vel   <= '0;
         xpos  <= '0;
         ypos  <= '0;
      end else begin
         state <= state_nxt;
         vel   <= vel_nxt;
         xpos  <= xpos_nxt;
         ypos  <= ypos_nxt;
      end
   end

   assign state_o = state;

endmodule
